// File: rtl/cel_clip_sequencer.sv
// Per-CEL front end: projects the four CEL corners with a serial shift-add
// multiplier, reduces them to an integer bounding box and clip-tests it.
module cel_clip_sequencer #(
  parameter int SIZE_W = 11,
  parameter int FIX_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              start_ready,
  input  logic              abort,
  input  logic [FIX_W-1:0]  xpos,
  input  logic [FIX_W-1:0]  ypos,
  input  logic [FIX_W-1:0]  hdx,
  input  logic [FIX_W-1:0]  hdy,
  input  logic [FIX_W-1:0]  vdx,
  input  logic [FIX_W-1:0]  vdy,
  input  logic [SIZE_W-1:0] cel_w,
  input  logic [SIZE_W-1:0] cel_h,
  input  logic [15:0]       clipx,
  input  logic [15:0]       clipy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              visible,
  output logic [15:0]       bbox_xmin,
  output logic [15:0]       bbox_xmax,
  output logic [15:0]       bbox_ymin,
  output logic [15:0]       bbox_ymax
);
  localparam int CNT_W = $clog2(SIZE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE_W - 1);
  localparam int IP = FIX_W - 16;

  typedef enum logic [2:0] {IDLE, MUL, SUM, TEST, ZERO, DONE} state_t;
  state_t state, state_nx;

  logic [FIX_W-1:0]  xpos_r, ypos_r, hdx_r, hdy_r, vdx_r, vdy_r;
  logic [FIX_W-1:0]  acc_hx, acc_hy, acc_vx, acc_vy;
  logic [SIZE_W-1:0] w_r, h_r;
  logic signed [15:0] clipx_r, clipy_r;
  logic [CNT_W-1:0]  cnt;
  logic              sum_ph;
  logic signed [15:0] cx [4];
  logic signed [15:0] cy [4];
  logic signed [15:0] xmin_r, xmax_r, ymin_r, ymax_r;

  function automatic logic signed [15:0] min4(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] m0, m1;
    m0 = (a < b) ? a : b;
    m1 = (c < d) ? c : d;
    return (m0 < m1) ? m0 : m1;
  endfunction

  function automatic logic signed [15:0] max4(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] m0, m1;
    m0 = (a > b) ? a : b;
    m1 = (c > d) ? c : d;
    return (m0 > m1) ? m0 : m1;
  endfunction

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (cel_w == '0 || cel_h == '0) ? ZERO : MUL;
      MUL:  if (abort) state_nx = IDLE; else if (cnt == CNT_LAST) state_nx = SUM;
      SUM:  if (abort) state_nx = IDLE; else if (sum_ph) state_nx = TEST;
      TEST: state_nx = abort ? IDLE : DONE;
      ZERO: state_nx = abort ? IDLE : DONE;
      DONE: if (abort || result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {xpos_r, ypos_r, hdx_r, hdy_r, vdx_r, vdy_r} <= '0;
      {acc_hx, acc_hy, acc_vx, acc_vy} <= '0;
      {w_r, h_r, clipx_r, clipy_r} <= '0;
      cnt <= '0;
      sum_ph <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
      end
      {xmin_r, xmax_r, ymin_r, ymax_r} <= '0;
      visible <= 1'b0;
      {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xpos_r <= xpos;  ypos_r <= ypos;
          hdx_r  <= hdx;   hdy_r  <= hdy;
          vdx_r  <= vdx;   vdy_r  <= vdy;
          w_r    <= cel_w; h_r    <= cel_h;
          clipx_r <= clipx; clipy_r <= clipy;
          {acc_hx, acc_hy, acc_vx, acc_vy} <= '0;
          cnt    <= '0;
          sum_ph <= 1'b0;
        end
        MUL: begin
          if (w_r[cnt]) begin
            acc_hx <= acc_hx + (hdx_r << cnt);
            acc_hy <= acc_hy + (hdy_r << cnt);
          end
          if (h_r[cnt]) begin
            acc_vx <= acc_vx + (vdx_r << cnt);
            acc_vy <= acc_vy + (vdy_r << cnt);
          end
          cnt <= cnt + CNT_W'(1);
        end
        // First SUM cycle takes the corner integer parts, second reduces them.
        SUM: if (!sum_ph) begin
          cx[0] <= 16'(xpos_r >> IP);
          cx[1] <= 16'((xpos_r + acc_hx) >> IP);
          cx[2] <= 16'((xpos_r + acc_vx) >> IP);
          cx[3] <= 16'((xpos_r + acc_hx + acc_vx) >> IP);
          cy[0] <= 16'(ypos_r >> IP);
          cy[1] <= 16'((ypos_r + acc_hy) >> IP);
          cy[2] <= 16'((ypos_r + acc_vy) >> IP);
          cy[3] <= 16'((ypos_r + acc_hy + acc_vy) >> IP);
          sum_ph <= 1'b1;
        end else begin
          xmin_r <= min4(cx[0], cx[1], cx[2], cx[3]);
          xmax_r <= max4(cx[0], cx[1], cx[2], cx[3]);
          ymin_r <= min4(cy[0], cy[1], cy[2], cy[3]);
          ymax_r <= max4(cy[0], cy[1], cy[2], cy[3]);
        end
        TEST: if (!abort) begin
          visible <= !(xmax_r < 16'sd0 || xmin_r > clipx_r ||
                       ymax_r < 16'sd0 || ymin_r > clipy_r);
          bbox_xmin <= xmin_r; bbox_xmax <= xmax_r;
          bbox_ymin <= ymin_r; bbox_ymax <= ymax_r;
        end
        ZERO: if (!abort) begin
          visible   <= 1'b0;
          bbox_xmin <= 16'(xpos_r >> IP); bbox_xmax <= 16'(xpos_r >> IP);
          bbox_ymin <= 16'(ypos_r >> IP); bbox_ymax <= 16'(ypos_r >> IP);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/cel_clip_sequencer.md
Name: cel_clip_sequencer

Overview:
- Per-CEL front end of the CEL engine.
- Accepts one CEL's position, horizontal/vertical deltas and size, and builds the four projected corner points with a serial shift-add multiplier.
- Reduces the corners to an integer bounding box and tests it against the clip window.
- Issues a single draw/skip decision with a valid/ready handshake, so the rasteriser is never started for off-screen CELs.

Parameters:
- SIZE_W, 11, width of cel_w/cel_h (max CEL dimension 2047).
- FIX_W, 32, width of fixed-point position/delta inputs; format is signed 16.16.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to evaluate a CEL; accepted when start && start_ready.
- start_ready  out  1  high only in IDLE.
- abort  in  1  synchronous cancel of the CEL in flight.
- xpos, ypos  in  FIX_W each  CEL origin, signed 16.16.
- hdx, hdy  in  FIX_W each  per-pixel horizontal step, signed 16.16.
- vdx, vdy  in  FIX_W each  per-row vertical step, signed 16.16.
- cel_w, cel_h  in  SIZE_W each  CEL width/height in pixels, unsigned.
- clipx, clipy  in  16 each  clip window max (signed integer).
- result_valid  out  1  decision available.
- result_ready  in  1  consumer accepts decision.
- visible  out  1  1 = draw, 0 = skip.
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  16 each  signed integer bounding box of the corners.

Behaviour:
- Reset: state=IDLE; start_ready=1; result_valid=0; visible=0; all bbox outputs=0. Reset has priority over every other input, including mid-operation.
- Accept: on a start && start_ready edge, latch all CEL inputs plus clipx/clipy into registers. Input changes after acceptance have no effect.
- States: IDLE -> MUL -> SUM -> TEST -> DONE -> IDLE. ZERO is a fast-path state.
- IDLE:
  - start with cel_w==0 or cel_h==0 -> ZERO.
  - start otherwise -> MUL; clear the four accumulators; bit counter=0.
- MUL: exactly SIZE_W cycles, LSB first. For bit i, when that bit of cel_w is set, add hdx<<i to acc_hx and hdy<<i to acc_hy. Likewise, when bit i of cel_h is set, add vdx<<i and vdy<<i. All arithmetic is FIX_W-bit two's complement; overflow wraps and is not flagged. Counter reaching SIZE_W-1 -> SUM.
- SUM: corners are
  - c0 = pos
  - c1 = pos + acc_h
  - c2 = pos + acc_v
  - c3 = pos + acc_h + acc_v
  - Computed per axis, FIX_W-bit wrap.
  - Integer part = bits [31:16] as signed 16.
  - Register the min and max of the four integer X and four integer Y values.
- TEST: not visible iff xmax<0, or xmin>clipx, or ymax<0, or ymin>clipy (all signed 16-bit compares; boundary equal to 0 or clip counts as visible). Register visible and bbox; set result_valid -> DONE.
- ZERO: on the next edge, bbox = integer part of (xpos, ypos) on all four outputs, visible=0, result_valid=1 -> DONE.
- Latency:
  - Normal path: result_valid high SIZE_W+3 clocks after the accepting edge (14 with defaults).
  - ZERO path: 1 clock after the accepting edge.
- DONE:
  - Outputs are held stable while result_ready=0.
  - On result_valid && result_ready, result_valid falls next edge -> IDLE.
  - A new start is not accepted in the same cycle (start_ready=0 in DONE), so back-to-back throughput is latency+2.
- abort: in MUL/SUM/TEST/ZERO -> IDLE next edge; no result is produced and outputs keep their previous values. In DONE, abort drops result_valid -> IDLE. In IDLE it is ignored.
- start is ignored outside IDLE.

Test Plan:
- Axis-aligned: xpos=10.0, ypos=20.0, hdx=1.0 (0x00010000), hdy=0, vdx=0, vdy=1.0, w=4, h=3, clip 319/239 -> result_valid 14 clocks after accept; bbox x 10..14, y 20..23; visible=1.
- Fully left: xpos=-100.0, hdx=1.0, w=50, h=10, vdy=1.0 -> xmax=-50; visible=0.
- Negative delta/boundary: xpos=2.0, hdx=0xFFFF0000 (-1.0), w=5, ypos=239.0, vdy=1.0, h=4 -> bbox x -3..2, y 239..243; visible=1 (ymin==clipy).
- Zero size: w=0, h=7, xpos=0x00050000 -> result_valid 1 clock after accept; all x bbox=5; visible=0; start_ready low until handshake.
- Backpressure and re-start: hold result_ready=0 for 20 cycles and pulse start -> outputs stable, start not accepted; assert result_ready -> IDLE; the next start is accepted.
- Abort/reset mid-MUL: abort at cycle 5 of MUL -> IDLE next edge, no result_valid. Repeat using reset -> all outputs at reset values.
